mac_sequencer: RTL and testbench
================================

Name: mac_sequencer

Overview:
Operand sequencer that drives a single MAC accumulator unit (enable/clear/Ain/Bin in, accumulated Cout back).
- Accepts a stream of paired operands over a valid/ready handshake and issues exactly VEC_LEN accumulate operations per dot product.
- Waits out the MAC's fixed pipeline latency, then returns the final accumulator value on a valid/ready result port.
- Sits between the operand FIFOs and the MAC in the matrix-vector datapath.

Parameters:
DATA_WIDTH, 8, operand width; the result is 3*DATA_WIDTH bits.
VEC_LEN, 8, number of operand pairs per dot product (must be >= 1).
MAC_LAT, 3, number of cycles from the cycle mac_en is high to the cycle the resulting sum is visible on mac_cout.

Ports:
clk  in  1  clock; all logic is on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse that begins one dot product; ignored unless idle
busy  out  1  high from the cycle after an accepted start until res_valid is consumed
op_valid  in  1  a_data/b_data hold a valid pair
op_ready  out  1  sequencer accepts a pair this cycle
a_data  in  DATA_WIDTH  operand A
b_data  in  DATA_WIDTH  operand B
mac_en  out  1  MAC accumulate enable
mac_clr  out  1  MAC accumulator clear
mac_a  out  DATA_WIDTH  MAC operand A
mac_b  out  DATA_WIDTH  MAC operand B
mac_cout  in  3*DATA_WIDTH  MAC accumulator value
res_valid  out  1  result available
res_ready  in  1  downstream accepts the result
res_data  out  3*DATA_WIDTH  captured dot-product result

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0, including busy, op_ready, mac_en, mac_clr, mac_a, mac_b, res_valid and res_data; all counters 0. The MAC shares rst_n, so reset mid-operation discards the partial sum with no recovery.
- All outputs are driven from registers. op_ready is the only output that may be a decode of state plus count.
- FSM states: IDLE, CLR, FEED, DRAIN, RESULT.
  - IDLE: when start is high, go to CLR. A start in any other state is ignored.
  - CLR: mac_clr is high for exactly one cycle, then go to FEED. mac_en is never high in the same cycle as mac_clr, because the MAC gives clear priority and the product would be lost.
  - FEED: op_ready = 1 while accepted < VEC_LEN.
    - On a handshake (op_valid & op_ready) at cycle t: mac_en = 1, mac_a = a_data and mac_b = b_data during cycle t+1, and the count increments.
    - On a cycle with no handshake, mac_en = 0 the next cycle and mac_a/mac_b hold their values.
    - When the VEC_LEN-th pair is accepted, op_ready drops the next cycle and the state goes to DRAIN.
  - DRAIN: counts MAC_LAT cycles after the last cycle with mac_en = 1 (cycle L). mac_cout is sampled into res_data at the end of cycle L+MAC_LAT, and res_valid rises in cycle L+MAC_LAT+1.
  - RESULT: res_valid and res_data hold until res_ready is high, then go to IDLE. busy falls and res_valid falls on the cycle after the handshake.
- The first mac_en is never earlier than the cycle after mac_clr.
- Arithmetic: no arithmetic is done here. res_data is a bit-exact copy of mac_cout; overflow wrap is owned by the MAC.
- Bubbles (op_valid low) in FEED extend the feed phase with no extra accumulates.
- Exactly VEC_LEN pairs are consumed per start; no pair is accepted outside FEED.
- Throughput: back-to-back vectors need a new start after the result is consumed; the minimum gap is set by the CLR and DRAIN states.

Decomposition:
- mac_pkg:
  - state enum (IDLE, CLR, FEED, DRAIN, RESULT).
  - MAC_LAT default constant, shared with the MAC owner so the two values stay in lockstep.
  - result width function (3*DATA_WIDTH).
- No sub-module; a single FSM plus two counters (accepted pairs, drain cycles).

Test Plan:
- Basic dot product: DATA_WIDTH=8, VEC_LEN=4, start, pairs A=1,2,3,4 and B=5,6,7,8 with op_valid held high → res_data=70. res_valid rises exactly MAC_LAT+1 cycles after the last mac_en cycle. One mac_clr pulse, four mac_en cycles.
- Maximum values: VEC_LEN=8, all pairs 255×255 → res_data=520200. No truncation on the 24-bit result.
- Bubbles: same vectors as the basic test with op_valid low for 2 cycles between pairs 2 and 3 → still 70, and mac_en is high for exactly 4 cycles total.
- Back-to-back: after result 70 is consumed, start again with all pairs 1×1 → res_data=4 (not 74), which proves the clear ran before the first mac_en.
- Backpressure and ignored start: hold res_ready low for 5 cycles → res_valid and res_data stay stable; a start pulse during RESULT is ignored (busy stays high, no mac_clr).
- Reset mid-FEED: assert rst_n low after 2 pairs → all outputs 0 immediately. A new start then feeding 1,2,3,4 × 5,6,7,8 → res_data=70.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC operand sequencer and the MAC it drives.
package mac_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StFeed,
        StDrain,
        StResult
    } state_e;

    // Keep in lockstep with the MAC pipeline depth.
    localparam int unsigned MAC_LAT_DEFAULT = 3;

    function automatic int unsigned res_width(input int unsigned data_width);
        return 3 * data_width;
    endfunction

endpackage

// File: rtl/mac_sequencer_if.sv
// Operand stream, MAC control and result port bundled for the MAC sequencer.
interface mac_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    import mac_pkg::*;

    localparam int unsigned RES_W = res_width(DATA_WIDTH);

    logic                  op_valid;
    logic                  op_ready;
    logic [DATA_WIDTH-1:0] a_data;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  mac_en;
    logic                  mac_clr;
    logic [DATA_WIDTH-1:0] mac_a;
    logic [DATA_WIDTH-1:0] mac_b;
    logic [RES_W-1:0]      mac_cout;
    logic                  res_valid;
    logic                  res_ready;
    logic [RES_W-1:0]      res_data;

    modport master (
        input  op_valid, a_data, b_data, mac_cout, res_ready,
        output op_ready, mac_en, mac_clr, mac_a, mac_b, res_valid, res_data
    );

    modport slave (
        output op_valid, a_data, b_data, mac_cout, res_ready,
        input  op_ready, mac_en, mac_clr, mac_a, mac_b, res_valid, res_data
    );

endinterface

// File: rtl/mac_sequencer.sv
// Feeds VEC_LEN operand pairs into a MAC, waits out its latency and returns the dot product.
module mac_sequencer
    import mac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned VEC_LEN    = 8,
    parameter int unsigned MAC_LAT    = MAC_LAT_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    mac_sequencer_if.master bus
);

    localparam int unsigned RES_W = res_width(DATA_WIDTH);
    localparam int unsigned CNT_W = $clog2(VEC_LEN + 1);
    localparam int unsigned DRN_W = $clog2(MAC_LAT + 2);

    localparam logic [CNT_W-1:0] LAST_PAIR = CNT_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0] ALL_PAIRS = CNT_W'(VEC_LEN);
    localparam logic [DRN_W-1:0] DRAIN_END = DRN_W'(MAC_LAT);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      acc_cnt_q, acc_cnt_d;
    logic [DRN_W-1:0]      drn_cnt_q, drn_cnt_d;
    logic                  busy_q, busy_d;
    logic                  mac_en_q, mac_en_d;
    logic                  mac_clr_q, mac_clr_d;
    logic [DATA_WIDTH-1:0] mac_a_q, mac_a_d;
    logic [DATA_WIDTH-1:0] mac_b_q, mac_b_d;
    logic                  res_valid_q, res_valid_d;
    logic [RES_W-1:0]      res_data_q, res_data_d;
    logic                  op_ready;
    logic                  op_hs;

    assign op_ready = (state_q == StFeed) && (acc_cnt_q < ALL_PAIRS);
    assign op_hs    = op_ready & bus.op_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            acc_cnt_q   <= '0;
            drn_cnt_q   <= '0;
            busy_q      <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            acc_cnt_q   <= acc_cnt_d;
            drn_cnt_q   <= drn_cnt_d;
            busy_q      <= busy_d;
            mac_en_q    <= mac_en_d;
            mac_clr_q   <= mac_clr_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StClr;
            StClr:    state_d = StFeed;
            StFeed:   if (op_hs && (acc_cnt_q == LAST_PAIR)) state_d = StDrain;
            StDrain:  if (drn_cnt_q == DRAIN_END) state_d = StResult;
            StResult: if (bus.res_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and counters.
    always_comb begin
        busy_d      = busy_q;
        mac_en_d    = 1'b0;
        mac_clr_d   = 1'b0;
        mac_a_d     = mac_a_q;
        mac_b_d     = mac_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        acc_cnt_d   = acc_cnt_q;
        drn_cnt_d   = drn_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d    = 1'b1;
                    mac_clr_d = 1'b1;
                    acc_cnt_d = '0;
                    drn_cnt_d = '0;
                end
            end
            StClr: ;
            StFeed: begin
                if (op_hs) begin
                    mac_en_d  = 1'b1;
                    mac_a_d   = bus.a_data;
                    mac_b_d   = bus.b_data;
                    acc_cnt_d = acc_cnt_q + 1'b1;
                end
            end
            StDrain: begin
                // First drain cycle carries the last mac_en; capture MAC_LAT cycles later.
                if (drn_cnt_q == DRAIN_END) begin
                    res_valid_d = 1'b1;
                    res_data_d  = bus.mac_cout;
                end else begin
                    drn_cnt_d = drn_cnt_q + 1'b1;
                end
            end
            StResult: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign busy          = busy_q;
    assign bus.op_ready  = op_ready;
    assign bus.mac_en    = mac_en_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.mac_a     = mac_a_q;
    assign bus.mac_b     = mac_b_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench: two sequencers (VEC_LEN 4 and 8) each driving a behavioural MAC.
module tb_mac_sequencer;
    import mac_pkg::*;

    localparam int unsigned DW  = 8;
    localparam int unsigned RW  = res_width(DW);
    localparam int          LAT = int'(MAC_LAT_DEFAULT);

    typedef int unsigned vec_t [8];

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic start4 = 1'b0;
    logic start8 = 1'b0;
    logic busy4;
    logic busy8;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mac_sequencer_if #(.DATA_WIDTH(DW)) bus4 ();
    mac_sequencer_if #(.DATA_WIDTH(DW)) bus8 ();

    mac_sequencer #(.DATA_WIDTH(DW), .VEC_LEN(4), .MAC_LAT(LAT)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .busy  (busy4),
        .bus   (bus4.master)
    );

    mac_sequencer #(.DATA_WIDTH(DW), .VEC_LEN(8), .MAC_LAT(LAT)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .busy  (busy8),
        .bus   (bus8.master)
    );

    // Behavioural MACs: clear has priority, sum visible LAT cycles after mac_en.
    logic [RW-1:0] pipe4 [LAT];
    logic [RW-1:0] pipe8 [LAT];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe4[i] <= '0;
        end else begin
            if (bus4.mac_clr) pipe4[0] <= '0;
            else if (bus4.mac_en) pipe4[0] <= pipe4[0] + RW'(bus4.mac_a) * RW'(bus4.mac_b);
            for (int i = 1; i < LAT; i++) pipe4[i] <= pipe4[i-1];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) pipe8[i] <= '0;
        end else begin
            if (bus8.mac_clr) pipe8[0] <= '0;
            else if (bus8.mac_en) pipe8[0] <= pipe8[0] + RW'(bus8.mac_a) * RW'(bus8.mac_b);
            for (int i = 1; i < LAT; i++) pipe8[i] <= pipe8[i-1];
        end
    end

    assign bus4.mac_cout = pipe4[LAT-1];
    assign bus8.mac_cout = pipe8[LAT-1];

    // Observation of the VEC_LEN=4 MAC interface, sampled on the falling edge.
    int          cyc          = 0;
    int          clr_cnt      = 0;
    int          en_cnt       = 0;
    int          overlap      = 0;
    int          clr_cyc      = -1;
    int          first_en_cyc = -1;
    int          last_en_cyc  = -1;
    int          rv_rise_cyc  = -1;
    logic        rv_prev      = 1'b0;
    logic [15:0] en_q [$];

    always @(negedge clk) begin
        cyc++;
        if (bus4.mac_clr) begin
            clr_cnt++;
            clr_cyc = cyc;
        end
        if (bus4.mac_en) begin
            en_cnt++;
            last_en_cyc = cyc;
            if (first_en_cyc < 0) first_en_cyc = cyc;
            en_q.push_back({bus4.mac_a, bus4.mac_b});
        end
        if (bus4.mac_en && bus4.mac_clr) overlap++;
        if (bus4.res_valid && !rv_prev) rv_rise_cyc = cyc;
        rv_prev = bus4.res_valid;
    end

    function automatic logic [RW-1:0] dot(input int n, input vec_t av, input vec_t bv);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < n; i++) s += 64'(av[i]) * 64'(bv[i]);
        return s[RW-1:0];
    endfunction

    task automatic clear_stats();
        clr_cnt      = 0;
        en_cnt       = 0;
        overlap      = 0;
        clr_cyc      = -1;
        first_en_cyc = -1;
        last_en_cyc  = -1;
        rv_rise_cyc  = -1;
        en_q.delete();
    endtask

    task automatic pulse_start4();
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
    endtask

    task automatic feed4(input int n, input vec_t av, input vec_t bv, input int bub_at,
                         input int bub_len, output bit to);
        int idx   = 0;
        int guard = 0;
        int bub   = 0;
        bit hs;
        while (idx < n && guard < 200) begin
            if (idx == bub_at && bub < bub_len) begin
                bus4.op_valid = 1'b0;
                bub++;
            end else begin
                bus4.op_valid = 1'b1;
                bus4.a_data   = av[idx][7:0];
                bus4.b_data   = bv[idx][7:0];
            end
            @(negedge clk);
            hs = bus4.op_valid && bus4.op_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            guard++;
        end
        bus4.op_valid = 1'b0;
        to = (idx < n);
    endtask

    task automatic wait_res4(output logic [RW-1:0] d, output bit to);
        int g = 0;
        to = 1'b1;
        d  = '0;
        while (g < 100) begin
            @(negedge clk); #1;
            if (bus4.res_valid) begin
                to = 1'b0;
                d  = bus4.res_data;
                break;
            end
            g++;
        end
    endtask

    task automatic consume4();
        bus4.res_ready = 1'b1;
        @(posedge clk); #1 bus4.res_ready = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic run_vec4(input int n, input vec_t av, input vec_t bv, input int bub_at,
                            input int bub_len, output logic [RW-1:0] res, output bit to);
        bit tf;
        bit tw;
        clear_stats();
        pulse_start4();
        feed4(n, av, bv, bub_at, bub_len, tf);
        wait_res4(res, tw);
        to = tf | tw;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy4, bus4.op_ready, bus4.mac_en, bus4.mac_clr, bus4.res_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {busy4, bus4.op_ready, bus4.mac_en, bus4.mac_clr, bus4.res_valid});
        end
        n_tests++;
        if ({bus4.mac_a, bus4.mac_b, bus4.res_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got a=%0d b=%0d res=%0d expected all 0",
                     bus4.mac_a, bus4.mac_b, bus4.res_data);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({busy4, bus4.op_ready, busy8, bus8.op_ready} !== 4'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got %b expected 0000",
                     {busy4, bus4.op_ready, busy8, bus8.op_ready});
        end
    endtask

    task automatic test_basic();
        vec_t          va = '{1, 2, 3, 4, 0, 0, 0, 0};
        vec_t          vb = '{5, 6, 7, 8, 0, 0, 0, 0};
        logic [RW-1:0] exp_res;
        logic [RW-1:0] res;
        bit            to;
        exp_res = dot(4, va, vb);
        run_vec4(4, va, vb, -1, 0, res, to);
        n_tests++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got 1 expected 0"); end
        n_tests++;
        if (res !== exp_res) begin
            n_fail++; $display("FAIL basic_data: got %0d expected %0d", res, exp_res);
        end
        n_tests++;
        if (rv_rise_cyc - last_en_cyc !== LAT + 1) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected %0d", rv_rise_cyc - last_en_cyc, LAT + 1);
        end
        n_tests++;
        if (clr_cnt !== 1 || en_cnt !== 4 || overlap !== 0) begin
            n_fail++;
            $display("FAIL basic_counts: got clr=%0d en=%0d overlap=%0d expected 1/4/0",
                     clr_cnt, en_cnt, overlap);
        end
        n_tests++;
        if (en_q.size() !== 4) begin
            n_fail++; $display("FAIL basic_pairs: got %0d pairs expected 4", en_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (en_q[i] !== {va[i][7:0], vb[i][7:0]}) begin
                    n_fail++;
                    $display("FAIL basic_pair%0d: got %h expected %h", i, en_q[i],
                             {va[i][7:0], vb[i][7:0]});
                end
            end
        end
        consume4();
        n_tests++;
        if ({busy4, bus4.res_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_release: got busy/valid=%b expected 00", {busy4, bus4.res_valid});
        end
    endtask

    task automatic test_max();
        vec_t          va = '{255, 255, 255, 255, 255, 255, 255, 255};
        logic [RW-1:0] exp_res;
        int            idx = 0;
        int            g   = 0;
        bit            got = 1'b0;
        exp_res = dot(8, va, va);
        @(posedge clk); #1 start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        bus8.op_valid = 1'b1;
        bus8.a_data   = 8'd255;
        bus8.b_data   = 8'd255;
        while (idx < 8 && g < 200) begin
            @(negedge clk);
            if (bus8.op_valid && bus8.op_ready) idx++;
            g++;
        end
        @(posedge clk); #1 bus8.op_valid = 1'b0;
        g = 0;
        while (!got && g < 100) begin
            @(negedge clk);
            got = bus8.res_valid;
            g++;
        end
        n_tests++;
        if (!got || idx != 8) begin
            n_fail++; $display("FAIL max_timeout: got pairs=%0d valid=%0b expected 8/1", idx, got);
        end
        n_tests++;
        if (bus8.res_data !== exp_res) begin
            n_fail++; $display("FAIL max_data: got %0d expected %0d", bus8.res_data, exp_res);
        end
        bus8.res_ready = 1'b1;
        @(posedge clk); #1 bus8.res_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({busy8, bus8.res_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL max_release: got busy/valid=%b expected 00", {busy8, bus8.res_valid});
        end
    endtask

    task automatic test_bubbles();
        vec_t          va = '{1, 2, 3, 4, 0, 0, 0, 0};
        vec_t          vb = '{5, 6, 7, 8, 0, 0, 0, 0};
        logic [RW-1:0] res;
        bit            to;
        run_vec4(4, va, vb, 2, 2, res, to);
        n_tests++;
        if (to !== 1'b0 || res !== dot(4, va, vb)) begin
            n_fail++;
            $display("FAIL bubble_data: got %0d (timeout=%0b) expected %0d", res, to, dot(4, va, vb));
        end
        n_tests++;
        if (en_cnt !== 4) begin
            n_fail++; $display("FAIL bubble_en_count: got %0d expected 4", en_cnt);
        end
        n_tests++;
        if (rv_rise_cyc - last_en_cyc !== LAT + 1) begin
            n_fail++;
            $display("FAIL bubble_latency: got %0d expected %0d", rv_rise_cyc - last_en_cyc, LAT + 1);
        end
        consume4();
    endtask

    task automatic test_back_to_back();
        vec_t          va = '{1, 2, 3, 4, 0, 0, 0, 0};
        vec_t          vb = '{5, 6, 7, 8, 0, 0, 0, 0};
        vec_t          v1 = '{1, 1, 1, 1, 0, 0, 0, 0};
        logic [RW-1:0] res;
        bit            to;
        run_vec4(4, va, vb, -1, 0, res, to);
        consume4();
        run_vec4(4, v1, v1, -1, 0, res, to);
        n_tests++;
        if (to !== 1'b0 || res !== dot(4, v1, v1)) begin
            n_fail++;
            $display("FAIL b2b_data: got %0d (timeout=%0b) expected %0d", res, to, dot(4, v1, v1));
        end
        n_tests++;
        if (clr_cnt !== 1 || first_en_cyc <= clr_cyc) begin
            n_fail++;
            $display("FAIL b2b_clear_order: got clr=%0d clr_cyc=%0d first_en=%0d expected 1 clear first",
                     clr_cnt, clr_cyc, first_en_cyc);
        end
        consume4();
    endtask

    task automatic test_backpressure();
        vec_t          va = '{1, 2, 3, 4, 0, 0, 0, 0};
        vec_t          vb = '{5, 6, 7, 8, 0, 0, 0, 0};
        logic [RW-1:0] res;
        bit            to;
        run_vec4(4, va, vb, -1, 0, res, to);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) start4 = 1'b1;
            @(posedge clk); #1 start4 = 1'b0;
            @(negedge clk); #1;
            n_tests++;
            if ({bus4.res_valid, busy4, bus4.op_ready} !== 3'b110
                || bus4.res_data !== dot(4, va, vb)) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: got valid/busy/ready=%b data=%0d expected 110 data=%0d",
                         k, {bus4.res_valid, busy4, bus4.op_ready}, bus4.res_data, dot(4, va, vb));
            end
        end
        consume4();
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (clr_cnt !== 1 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start: got clr=%0d busy=%0b expected 1/0", clr_cnt, busy4);
        end
    endtask

    task automatic test_reset_mid_feed();
        vec_t          va = '{1, 2, 3, 4, 0, 0, 0, 0};
        vec_t          vb = '{5, 6, 7, 8, 0, 0, 0, 0};
        logic [RW-1:0] res;
        bit            to;
        clear_stats();
        pulse_start4();
        feed4(2, va, vb, -1, 0, to);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy4, bus4.op_ready, bus4.mac_en, bus4.mac_clr, bus4.res_valid} !== 5'b0
            || {bus4.mac_a, bus4.mac_b, bus4.res_data} !== '0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ctrl=%b a=%0d b=%0d res=%0d expected all 0",
                     {busy4, bus4.op_ready, bus4.mac_en, bus4.mac_clr, bus4.res_valid},
                     bus4.mac_a, bus4.mac_b, bus4.res_data);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        run_vec4(4, va, vb, -1, 0, res, to);
        n_tests++;
        if (to !== 1'b0 || res !== dot(4, va, vb)) begin
            n_fail++;
            $display("FAIL midreset_rerun: got %0d (timeout=%0b) expected %0d", res, to, dot(4, va, vb));
        end
        consume4();
    endtask

    task automatic test_random();
        vec_t          va;
        vec_t          vb;
        logic [RW-1:0] res;
        bit            to;
        int            hold;
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 8; i++) begin
                va[i] = $urandom_range(0, 255);
                vb[i] = $urandom_range(0, 255);
            end
            hold = int'($urandom_range(0, 3));
            run_vec4(4, va, vb, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), res, to);
            n_tests++;
            if (to !== 1'b0 || res !== dot(4, va, vb) || en_cnt !== 4) begin
                n_fail++;
                $display("FAIL rand%0d_data: got %0d en=%0d (timeout=%0b) expected %0d en=4",
                         it, res, en_cnt, to, dot(4, va, vb));
            end
            n_tests++;
            if (en_q.size() != 4 || en_q[0] !== {va[0][7:0], vb[0][7:0]}
                || en_q[3] !== {va[3][7:0], vb[3][7:0]}) begin
                n_fail++;
                $display("FAIL rand%0d_pairs: got %0d pairs expected 4 in order", it, en_q.size());
            end
            repeat (hold) @(negedge clk);
            #1;
            n_tests++;
            if (bus4.res_valid !== 1'b1 || bus4.res_data !== dot(4, va, vb)) begin
                n_fail++;
                $display("FAIL rand%0d_hold: got valid=%0b data=%0d expected 1/%0d",
                         it, bus4.res_valid, bus4.res_data, dot(4, va, vb));
            end
            consume4();
        end
    endtask

    initial begin
        bus4.op_valid  = 1'b0;
        bus4.a_data    = '0;
        bus4.b_data    = '0;
        bus4.res_ready = 1'b0;
        bus8.op_valid  = 1'b0;
        bus8.a_data    = '0;
        bus8.b_data    = '0;
        bus8.res_ready = 1'b0;
        test_reset();
        test_basic();
        test_max();
        test_bubbles();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_feed();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
